// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : debounce_multi
// Brief    : N-channel button debouncer with 2-flop synchroniser, stability
//            counter and rise/fall strobes. Optional long-press pulse with
//            macro DEBOUNCE_HOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_multi #(
  parameter int   CHANNELS      = 4,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_VAL     = 1'b0,
  parameter int   HOLD_CYCLES   = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pb_in,
  output logic [CHANNELS-1:0] pb_debounced,
  output logic [CHANNELS-1:0] pb_rise,
  output logic [CHANNELS-1:0] pb_fall,
  output logic [CHANNELS-1:0] pb_hold
);

  localparam int               CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);

`ifdef DEBOUNCE_HOLD_EN
  localparam int                HOLD_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] c_hold_max = HOLD_W'(HOLD_CYCLES);
`endif

  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic             r_s1;
    logic             r_s;
    logic             r_db;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;

    assign w_diff = (r_s != r_db);

    // A change is accepted only after STABLE_CYCLES disagreeing samples in a row
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1   <= RESET_VAL;
        r_s    <= RESET_VAL;
        r_db   <= RESET_VAL;
        r_cnt  <= '0;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_s1   <= pb_in[gi];
        r_s    <= r_s1;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_db   <= r_s;
          r_cnt  <= '0;
          r_rise <= r_s;
          r_fall <= ~r_s;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign pb_debounced[gi] = r_db;
    assign pb_rise[gi]      = r_rise;
    assign pb_fall[gi]      = r_fall;

`ifdef DEBOUNCE_HOLD_EN
    logic [HOLD_W-1:0] r_hcnt;
    logic              r_hold;

    // Counter saturates at HOLD_CYCLES so a long press yields a single pulse
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_hcnt <= '0;
        r_hold <= 1'b0;
      end else begin
        r_hold <= 1'b0;
        if (!r_db) begin
          r_hcnt <= '0;
        end else if (r_hcnt != c_hold_max) begin
          r_hcnt <= r_hcnt + HOLD_W'(1);
          r_hold <= (r_hcnt == c_hold_max - HOLD_W'(1));
        end
      end
    end

    assign pb_hold[gi] = r_hold;
`else
    // Hold logic absent; the term keeps HOLD_CYCLES referenced and folds to 0
    assign pb_hold[gi] = 1'b0 & (HOLD_CYCLES > 0);
`endif
  end

endmodule
`default_nettype wire
